conv2d_engine: RTL and testbench

- Parametrised successor to the fixed 5x5/3x3 window walker.
- Scans a KxK window over an IMG_H x IMG_W frame held in external synchronous-read memory, then multiplies each fetched pixel by a programmable signed kernel coefficient and accumulates.
- Writes one scaled, clamped result per window position to the output memory.
- Sits between the frame RAM and the result RAM, controlled by the start/ready handshake.

---
 rtl/conv2d_if.sv | 31 +++
 rtl/conv2d_engine.sv | 210 +++++++++++++++++++++
 tb/tb_conv2d_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_if.sv
// Bus bundle between the convolution engine, its frame/result memories and the
// controlling host: start/ready handshake, coefficient port, read and write ports.
interface conv2d_if #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 8,
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic                     ready;
    logic                     busy;
    logic                     coef_we;
    logic [IDX_W-1:0]         coef_idx;
    logic signed [COEF_W-1:0] coef_in;
    logic                     rd_en;
    logic [ADDR_W-1:0]        addr_rd;
    logic [DATA_W-1:0]        d_in;
    logic                     wr_en;
    logic [ADDR_W-1:0]        addr_wr;
    logic [DATA_W-1:0]        d_out;

    modport master (
        output start, coef_we, coef_idx, coef_in, d_in,
        input  ready, busy, rd_en, addr_rd, wr_en, addr_wr, d_out
    );

    modport slave (
        input  start, coef_we, coef_idx, coef_in, d_in,
        output ready, busy, rd_en, addr_rd, wr_en, addr_wr, d_out
    );
endinterface

// File: rtl/conv2d_engine.sv
// KxK signed-coefficient convolution over an IMG_H x IMG_W frame in sync-read RAM;
// one shifted, clamped result per window position is written to the result RAM.
module conv2d_engine #(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int K      = 3,
    parameter int DATA_W = 12,
    parameter int COEF_W = 8,
    parameter int ADDR_W = 17,
    parameter int SHIFT  = 4
) (
    input logic     clk,
    input logic     rst,
    conv2d_if.slave bus
);
    // state   | meaning
    // S_IDLE  | waiting for start, coefficients writable
    // S_FETCH | issuing K*K window reads, accumulating the previous read
    // S_DRAIN | last product lands in the accumulator
    // S_WRITE | result pulse, then next window or done
    // S_DONE  | frame complete, ready held, coefficients writable
    localparam int KK     = K * K;
    localparam int IDX_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int ACC_W  = DATA_W + COEF_W + 1 + IDX_W;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int CNT_W  = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
    localparam int STEP_W = $clog2(KK + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         out_r_q, out_r_d, out_c_q, out_c_d;
    logic [CNT_W-1:0]         kr_q, kr_d, kc_q, kc_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [COEF_W-1:0] coef_q [KK];
    logic signed [COEF_W-1:0] coef_d [KK];
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        addr_rd_q, addr_rd_d;
    logic [IDX_W-1:0]         idx0_q, idx0_d;
    logic                     mac_vld_q, mac_vld_d;
    logic [IDX_W-1:0]         mac_idx_q, mac_idx_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        addr_wr_q, addr_wr_d;
    logic [DATA_W-1:0]        d_out_q, d_out_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;

    logic signed [COEF_W-1:0] coef_sel;
    logic signed [ACC_W-1:0]  pix_ext, coef_ext, prod, acc_sh;
    logic                     do_issue;
    logic [CNT_W-1:0]         iss_kr, iss_kc;
    logic [STEP_W-1:0]        iss_step;
    logic                     cfg_ok;

    always_comb begin
        state_d   = state_q;
        out_r_d   = out_r_q;
        out_c_d   = out_c_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        step_d    = step_q;
        acc_d     = acc_q;
        coef_d    = coef_q;
        rd_en_d   = 1'b0;
        addr_rd_d = addr_rd_q;
        idx0_d    = idx0_q;
        mac_vld_d = rd_en_q;
        mac_idx_d = idx0_q;
        wr_en_d   = 1'b0;
        addr_wr_d = addr_wr_q;
        d_out_d   = d_out_q;
        ready_d   = ready_q;
        do_issue  = 1'b0;
        iss_kr    = kr_q;
        iss_kc    = kc_q;
        iss_step  = step_q;
        coef_sel  = '0;

        cfg_ok = (state_q == S_IDLE) || (state_q == S_DONE);
        for (int i = 0; i < KK; i++) begin
            if (cfg_ok && bus.coef_we && bus.coef_idx == IDX_W'(i)) coef_d[i] = bus.coef_in;
            if (mac_idx_q == IDX_W'(i)) coef_sel = coef_q[i];
        end

        // Pixel is unsigned, so zero-extend it before the signed multiply.
        pix_ext  = {{(ACC_W - DATA_W){1'b0}}, bus.d_in};
        coef_ext = {{(ACC_W - COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
        prod     = pix_ext * coef_ext;
        if (mac_vld_q) acc_d = acc_q + prod;

        acc_sh = acc_q >>> SHIFT;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_FETCH;
                    out_r_d  = '0;
                    out_c_d  = '0;
                    acc_d    = '0;
                    ready_d  = 1'b0;
                    do_issue = 1'b1;
                    iss_kr   = '0;
                    iss_kc   = '0;
                    iss_step = '0;
                end else if (state_q == S_DONE) begin
                    ready_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (step_q == STEP_W'(KK)) state_d = S_DRAIN;
                else do_issue = 1'b1;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                wr_en_d   = 1'b1;
                addr_wr_d = ADDR_W'(out_r_q) * ADDR_W'(OUT_W) + ADDR_W'(out_c_q);
                if (acc_sh[ACC_W-1])                d_out_d = '0;
                else if (|acc_sh[ACC_W-2:DATA_W])   d_out_d = '1;
                else                                d_out_d = acc_sh[DATA_W-1:0];
                acc_d = '0;
                if (out_r_q == CNT_W'(OUT_H - 1) && out_c_q == CNT_W'(OUT_W - 1)) begin
                    state_d = S_DONE;
                end else begin
                    if (out_c_q == CNT_W'(OUT_W - 1)) begin
                        out_c_d = '0;
                        out_r_d = out_r_q + 1'b1;
                    end else begin
                        out_c_d = out_c_q + 1'b1;
                    end
                    state_d  = S_FETCH;
                    do_issue = 1'b1;
                    iss_kr   = '0;
                    iss_kc   = '0;
                    iss_step = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Column-major walk inside the window: kr runs fastest.
        if (do_issue) begin
            rd_en_d   = 1'b1;
            addr_rd_d = (ADDR_W'(out_r_d) + ADDR_W'(iss_kr)) * ADDR_W'(IMG_W)
                        + ADDR_W'(out_c_d) + ADDR_W'(iss_kc);
            idx0_d    = IDX_W'(iss_kr * CNT_W'(K) + iss_kc);
            step_d    = iss_step + 1'b1;
            if (iss_kr == CNT_W'(K - 1)) begin
                kr_d = '0;
                kc_d = iss_kc + 1'b1;
            end else begin
                kr_d = iss_kr + 1'b1;
                kc_d = iss_kc;
            end
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            out_r_q   <= '0;
            out_c_q   <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            step_q    <= '0;
            acc_q     <= '0;
            for (int i = 0; i < KK; i++) coef_q[i] <= '0;
            rd_en_q   <= 1'b0;
            addr_rd_q <= '0;
            idx0_q    <= '0;
            mac_vld_q <= 1'b0;
            mac_idx_q <= '0;
            wr_en_q   <= 1'b0;
            addr_wr_q <= '0;
            d_out_q   <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_r_q   <= out_r_d;
            out_c_q   <= out_c_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            coef_q    <= coef_d;
            rd_en_q   <= rd_en_d;
            addr_rd_q <= addr_rd_d;
            idx0_q    <= idx0_d;
            mac_vld_q <= mac_vld_d;
            mac_idx_q <= mac_idx_d;
            wr_en_q   <= wr_en_d;
            addr_wr_q <= addr_wr_d;
            d_out_q   <= d_out_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.addr_rd = addr_rd_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.addr_wr = addr_wr_q;
    assign bus.d_out   = d_out_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine: a SHIFT=0 instance for most scenarios and a
// SHIFT=4 instance for the scaling case, each with a sync-read frame memory model.
module tb_conv2d_engine;
    localparam int DATA_W = 12;
    localparam int COEF_W = 8;
    localparam int ADDR_W = 17;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv2d_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) b0 ();
    conv2d_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) b4 ();

    conv2d_engine #(.SHIFT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    conv2d_engine #(.SHIFT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    int checks = 0;
    int fails  = 0;
    int pix_mode = 0;
    int cyc = 0;

    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        return (pix_mode == 1) ? 12'hFFF : a[DATA_W-1:0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b0.rd_en) b0.d_in <= pix(b0.addr_rd);
        if (b4.rd_en) b4.d_in <= pix(b4.addr_rd);
    end

    int wr_n = 0, rd_n = 0, w4_n = 0;
    int wr_a [256];
    int wr_d [256];
    int wr_c [256];
    int rd_a [1024];
    int w4_d [64];

    always @(negedge clk) begin
        if (b0.wr_en && wr_n < 256) begin
            wr_a[wr_n] = int'(b0.addr_wr);
            wr_d[wr_n] = int'(b0.d_out);
            wr_c[wr_n] = cyc;
            wr_n++;
        end
        if (b0.rd_en && rd_n < 1024) begin
            rd_a[rd_n] = int'(b0.addr_rd);
            rd_n++;
        end
        if (b4.wr_en && w4_n < 64) begin
            w4_d[w4_n] = int'(b4.d_out);
            w4_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_coef0(input int idx, input int val);
        b0.coef_we  = 1'b1;
        b0.coef_idx = IDX_W'(idx);
        b0.coef_in  = COEF_W'(val);
        @(negedge clk);
        b0.coef_we  = 1'b0;
    endtask

    task automatic start0(output int edge_c);
        b0.start = 1'b1;
        edge_c   = cyc + 1;
        @(negedge clk);
        b0.start = 1'b0;
    endtask

    task automatic wait_ready0(output int rdy_c);
        rdy_c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b0.ready === 1'b1) begin
                rdy_c = cyc;
                break;
            end
        end
        chk("frame_done_in_time", 32'(rdy_c >= 0), 1);
    endtask

    // kind 0: pixel=address, all coef 1; kind 1: saturated; kind 2: clamped to zero
    task automatic check_frame0(input string tag, input int base, input int kind);
        int e;
        for (int w = 0; w < 9; w++) begin
            case (kind)
                0:       e = 54 + 9 * (5 * (w / 3) + (w % 3));
                1:       e = 4095;
                default: e = 0;
            endcase
            chk({tag, "_addr_wr"}, 32'(wr_a[base + w]), 32'(w));
            chk({tag, "_d_out"}, 32'(wr_d[base + w]), 32'(e));
        end
    endtask

    int st, rdy, base, rbase, nb;
    int first_rd [9];
    int top_left [9];

    initial begin
        first_rd = '{0, 5, 10, 1, 6, 11, 2, 7, 12};
        top_left = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        b0.start = 1'b0; b0.coef_we = 1'b0; b0.coef_idx = '0; b0.coef_in = '0;
        b4.start = 1'b0; b4.coef_we = 1'b0; b4.coef_idx = '0; b4.coef_in = '0;

        tick(3);
        chk("rst_flags", 32'({b0.rd_en, b0.wr_en, b0.busy, b0.ready}), 0);
        chk("rst_addr_rd", 32'(b0.addr_rd), 0);
        chk("rst_addr_wr", 32'(b0.addr_wr), 0);
        chk("rst_d_out", 32'(b0.d_out), 0);
        rst = 1'b1;
        tick(2);

        // Scenario 1: pixel = address, all coefficients 1
        for (int i = 0; i < 9; i++) set_coef0(i, 1);
        base = wr_n; rbase = rd_n;
        start0(st);
        chk("busy_after_start", 32'(b0.busy), 1);
        wait_ready0(rdy);
        for (int i = 0; i < 9; i++) chk("first_window_addr_rd", 32'(rd_a[rbase + i]), 32'(first_rd[i]));
        check_frame0("base", base, 0);
        chk("base_write_count", 32'(wr_n - base), 9);
        chk("first_wr_latency", 32'(wr_c[base] - st), 11);
        chk("ready_rise_cycle", 32'(rdy - st), 100);
        chk("busy_in_done", 32'(b0.busy), 0);

        // Scenario 2: saturation; coefficients rewritten in DONE, start from DONE
        pix_mode = 1;
        for (int i = 0; i < 9; i++) set_coef0(i, 2);
        base = wr_n;
        start0(st);
        chk("ready_drop_on_start", 32'(b0.ready), 0);
        chk("busy_on_restart", 32'(b0.busy), 1);
        wait_ready0(rdy);
        check_frame0("sat", base, 1);

        // Scenario 3: centre coefficient -1 only -> negative clamp
        pix_mode = 0;
        for (int i = 0; i < 9; i++) set_coef0(i, (i == 4) ? -1 : 0);
        base = wr_n;
        start0(st);
        wait_ready0(rdy);
        check_frame0("neg", base, 2);

        // Scenario 4: SHIFT=4 instance, coef[0]=16 returns each window's top-left pixel
        b4.coef_we = 1'b1; b4.coef_idx = '0; b4.coef_in = 8'sd16;
        @(negedge clk);
        b4.coef_we = 1'b0;
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b4.ready === 1'b1) break;
        end
        chk("shift4_ready", 32'(b4.ready), 1);
        chk("shift4_write_count", 32'(w4_n), 9);
        for (int i = 0; i < 9; i++) chk("shift4_d_out", 32'(w4_d[i]), 32'(top_left[i]));

        // Scenario 5: reset during window 4's fetch, then a clean rerun
        for (int i = 0; i < 9; i++) set_coef0(i, 1);
        base = wr_n;
        start0(st);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_n >= base + 4) break;
        end
        tick(3);
        chk("pre_abort_writes", 32'(wr_n - base), 4);
        rst = 1'b0;
        #1;
        chk("abort_flags", 32'({b0.rd_en, b0.wr_en, b0.busy, b0.ready}), 0);
        chk("abort_addr_rd", 32'(b0.addr_rd), 0);
        chk("abort_addr_wr", 32'(b0.addr_wr), 0);
        chk("abort_d_out", 32'(b0.d_out), 0);
        nb = wr_n;
        tick(30);
        chk("no_write_after_abort", 32'(wr_n - nb), 0);
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 9; i++) set_coef0(i, 1);
        base = wr_n;
        start0(st);
        wait_ready0(rdy);
        check_frame0("rerun", base, 0);

        // Scenario 6: coef_we and start while busy are ignored
        base = wr_n;
        start0(st);
        tick(3);
        b0.coef_we = 1'b1; b0.coef_idx = '0; b0.coef_in = -8'sd5; b0.start = 1'b1;
        tick(1);
        b0.coef_we = 1'b0; b0.start = 1'b0;
        tick(20);
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        wait_ready0(rdy);
        check_frame0("busy_ign", base, 0);
        chk("busy_ign_write_count", 32'(wr_n - base), 9);
        chk("busy_ign_ready_cycle", 32'(rdy - st), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
